sysid_boot_checker: RTL

//  Post-reset sequencer for the system-ID slave: issues Avalon-MM reads of ID (addr 0) and timestamp (addr 1),

---
 rtl/sysid_boot_pkg.sv | 21 ++
 rtl/sysid_read_timer.sv | 42 ++++
 rtl/sysid_boot_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sysid_boot_pkg.sv
// Shared types and constants for the system-ID boot checker.
package sysid_boot_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      RD_ID  = 3'd1,
      LAT_ID = 3'd2,
      RD_TS  = 3'd3,
      LAT_TS = 3'd4,
      CHECK  = 3'd5
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_ID      = 2'b01;
   localparam logic [1:0] ERR_TS      = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   localparam logic ADDR_ID = 1'b0;
   localparam logic ADDR_TS = 1'b1;

endpackage

// File: rtl/sysid_read_timer.sv
// Per-read timeout counter (saturating, 16 bit) and fixed read-latency counter.
module sysid_read_timer #(
   parameter int READ_LATENCY   = 0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clock,
   input  logic reset_n,
   input  logic clear,
   input  logic enable,
   input  logic lat_en,
   output logic latency_done,
   output logic timed_out
);

   // tcnt holds the number of completed cycles of the current read, so the
   // cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   localparam logic [1:0]  LAT_LAST = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

   logic [15:0] tcnt;
   logic [1:0]  lcnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         tcnt <= '0;
         lcnt <= '0;
      end else begin
         if (clear || !enable)
            tcnt <= '0;
         else if (tcnt != 16'hFFFF)
            tcnt <= tcnt + 16'd1;
         if (!lat_en)
            lcnt <= '0;
         else
            lcnt <= lcnt + 2'd1;
      end
   end

   assign timed_out    = enable && (tcnt >= TMO_LAST);
   assign latency_done = (READ_LATENCY > 0) && lat_en && (lcnt == LAT_LAST);

endmodule

// File: rtl/sysid_boot_checker.sv
// Post-reset system-ID read/compare sequencer gating processor release.
// Optional timestamp read/compare enabled by defining SYSID_TIMESTAMP_CHECK_EN.
module sysid_boot_checker
   import sysid_boot_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'hAAAA_AAAA,
   parameter logic [31:0] EXPECTED_TS    = 32'h5378_E5B4,
   parameter int          READ_LATENCY   = 0,
   parameter int          TIMEOUT_CYCLES = 255,
   parameter int          MAX_RETRIES    = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   output logic        busy,
   output logic        done,
   output logic        sys_ok,
   output logic        sys_err,
   output logic [1:0]  err_code,
   output logic [31:0] id_value,
   output logic [31:0] ts_value,
   output state_t      state_dbg
);

`ifdef SYSID_TIMESTAMP_CHECK_EN
   localparam bit TS_CHECK = 1'b1;
`else
   localparam bit TS_CHECK = 1'b0;
`endif

   state_t     state;
   logic [3:0] retry_cnt;
   logic       auto_start;
   logic       timeout_seen;
   logic [1:0] verdict;
   logic       in_rd, in_lat, accept, rd_complete;
   logic       latency_done, timed_out;

   // Avalon read handshake: a read is accepted in the cycle where avm_read is
   // high and avm_waitrequest is low; address and read stay frozen until then.
   assign in_rd       = (state == RD_ID) || (state == RD_TS);
   assign in_lat      = (state == LAT_ID) || (state == LAT_TS);
   assign accept      = in_rd && avm_read && !avm_waitrequest;
   assign rd_complete = (accept && (READ_LATENCY == 0)) || latency_done;
   assign state_dbg   = state;

   sysid_read_timer #(
      .READ_LATENCY   (READ_LATENCY),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clock        (clock),
      .reset_n      (reset_n),
      .clear        (rd_complete),
      .enable       (in_rd || in_lat),
      .lat_en       (in_lat),
      .latency_done (latency_done),
      .timed_out    (timed_out)
   );

   always_comb begin
      verdict = ERR_NONE;
      if (timeout_seen)
         verdict = ERR_TIMEOUT;
      else if (id_value != EXPECTED_ID)
         verdict = ERR_ID;
      else if (TS_CHECK && (ts_value != EXPECTED_TS))
         verdict = ERR_TS;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state        <= IDLE;
         auto_start   <= 1'b1;
         retry_cnt    <= '0;
         timeout_seen <= 1'b0;
         avm_read     <= 1'b0;
         avm_address  <= ADDR_ID;
         busy         <= 1'b0;
         done         <= 1'b0;
         sys_ok       <= 1'b0;
         sys_err      <= 1'b0;
         err_code     <= ERR_NONE;
         id_value     <= '0;
         ts_value     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            // busy still high here means this is the done cycle: start is dropped.
            IDLE: begin
               if (busy) begin
                  busy <= 1'b0;
               end else if (start || auto_start) begin
                  auto_start  <= 1'b0;
                  retry_cnt   <= '0;
                  busy        <= 1'b1;
                  state       <= RD_ID;
                  avm_read    <= 1'b1;
                  avm_address <= ADDR_ID;
               end
            end
            RD_ID, LAT_ID: begin
               if (rd_complete) begin
                  id_value <= avm_readdata;
`ifdef SYSID_TIMESTAMP_CHECK_EN
                  state       <= RD_TS;
                  avm_read    <= 1'b1;
                  avm_address <= ADDR_TS;
`else
                  state    <= CHECK;
                  avm_read <= 1'b0;
`endif
               end else if (accept) begin
                  state    <= LAT_ID;
                  avm_read <= 1'b0;
               end else if (timed_out) begin
                  state        <= CHECK;
                  avm_read     <= 1'b0;
                  timeout_seen <= 1'b1;
               end
            end
`ifdef SYSID_TIMESTAMP_CHECK_EN
            RD_TS, LAT_TS: begin
               if (rd_complete) begin
                  ts_value <= avm_readdata;
                  state    <= CHECK;
                  avm_read <= 1'b0;
               end else if (accept) begin
                  state    <= LAT_TS;
                  avm_read <= 1'b0;
               end else if (timed_out) begin
                  state        <= CHECK;
                  avm_read     <= 1'b0;
                  timeout_seen <= 1'b1;
               end
            end
`endif
            CHECK: begin
               timeout_seen <= 1'b0;
               if (verdict == ERR_NONE) begin
                  sys_ok    <= 1'b1;
                  sys_err   <= 1'b0;
                  err_code  <= ERR_NONE;
                  done      <= 1'b1;
                  retry_cnt <= '0;
                  state     <= IDLE;
               end else begin
                  err_code <= verdict;
                  if (int'(retry_cnt) < MAX_RETRIES) begin
                     retry_cnt   <= retry_cnt + 4'd1;
                     state       <= RD_ID;
                     avm_read    <= 1'b1;
                     avm_address <= ADDR_ID;
                  end else begin
                     sys_ok  <= 1'b0;
                     sys_err <= 1'b1;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               avm_read <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
